// File: rtl/priority_arbiter_rr.sv
// Registered N-way request arbiter: fixed priority (MSB wins) or round-robin,
// presenting one winner per cycle on a valid/ready output held under backpressure.
module priority_arbiter_rr #(
   parameter  int unsigned N    = 8,
   parameter  int unsigned MODE = 0,
   localparam int unsigned W    = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] grant_idx,
   output logic [N-1:0] grant_onehot
);

   localparam int NI = int'(N);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   state_e       state_q;
   logic         out_valid_q;
   logic [W-1:0] grant_idx_q;
   logic [N-1:0] grant_onehot_q;
   logic [W-1:0] last_ptr_q;

   logic [W-1:0] search_ptr_c;
   logic [W-1:0] win_idx_c;
   logic [N-1:0] win_onehot_c;
   logic         win_found_c;

   // While holding, the grant being retired becomes the lowest-priority requester.
   always_comb begin
      search_ptr_c = (state_q == HOLD) ? grant_idx_q : last_ptr_q;
      if (MODE == 0) begin
         search_ptr_c = '0;
      end
   end

   // Descend from search_ptr-1, wrapping 0 -> N-1, ending at search_ptr itself.
   always_comb begin
      int j;
      win_found_c = 1'b0;
      win_idx_c   = '0;
      j           = 0;
      for (int k = 1; k <= NI; k++) begin
         j = int'(search_ptr_c) - k;
         if (j < 0) begin
            j = j + NI;
         end
         if (!win_found_c && req[W'(j)]) begin
            win_found_c = 1'b1;
            win_idx_c   = W'(j);
         end
      end
      win_onehot_c = N'(1) << win_idx_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         out_valid_q    <= 1'b0;
         grant_idx_q    <= '0;
         grant_onehot_q <= '0;
         last_ptr_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_found_c) begin
                  state_q        <= HOLD;
                  out_valid_q    <= 1'b1;
                  grant_idx_q    <= win_idx_c;
                  grant_onehot_q <= win_onehot_c;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  last_ptr_q <= grant_idx_q;
                  if (win_found_c) begin
                     grant_idx_q    <= win_idx_c;
                     grant_onehot_q <= win_onehot_c;
                  end else begin
                     state_q        <= IDLE;
                     out_valid_q    <= 1'b0;
                     grant_idx_q    <= '0;
                     grant_onehot_q <= '0;
                  end
               end
            end
         endcase
      end
   end

   assign out_valid    = out_valid_q;
   assign grant_idx    = grant_idx_q;
   assign grant_onehot = grant_onehot_q;

endmodule
